// File: rtl/tt_mux_sel_driver.sv
// tt_mux_sel_driver: drives the TT design-select pad protocol (sel_rst_n / sel_inc / ena)
// from a valid/ready address request, using incremental selection when possible.
module tt_mux_sel_driver #(
    parameter int ADDR_W    = 10,
    parameter int ADDR_MAX  = 383,
    parameter int PHASE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_ena,
    input  logic              req_fast,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              ctrl_sel_rst_n,
    output logic              ctrl_sel_inc,
    output logic              ctrl_ena
);
    typedef enum logic [2:0] {IDLE, RST_LO, RST_HI, INC_HI, INC_LO, FINISH} state_t;

    localparam logic [ADDR_W-1:0] AMAX    = ADDR_W'(ADDR_MAX);
    localparam logic [7:0]        PH_LAST = 8'(PHASE_CYC - 1);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] n_q, n_d, cur_q, cur_d;
    logic              rst_n_q, rst_n_d, inc_q, inc_d, ena_q, ena_d;
    logic              done_q, done_d, err_q, err_d;
    logic              sel_valid_q, sel_valid_d, req_ena_q, req_ena_d, rej_q, rej_d;
    logic              ph_end, fast_ok;

    assign ph_end  = cnt_q == PH_LAST;
    assign fast_ok = req_fast & sel_valid_q & (req_addr >= cur_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 8'd1;
        n_d         = n_q;
        cur_d       = cur_q;
        rst_n_d     = rst_n_q;
        inc_d       = inc_q;
        ena_d       = ena_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        sel_valid_d = sel_valid_q;
        req_ena_d   = req_ena_q;
        rej_d       = rej_q;
        case (state_q)
            IDLE: if (req_valid) begin
                cnt_d     = '0;
                req_ena_d = req_ena;
                rej_d     = req_addr > AMAX;
                if (req_addr > AMAX) begin
                    state_d = FINISH;
                end else if (fast_ok) begin
                    ena_d   = 1'b0;
                    n_d     = req_addr - cur_q;
                    state_d = (req_addr == cur_q) ? FINISH : INC_HI;
                    inc_d   = req_addr != cur_q;
                    cur_d   = (req_addr == cur_q) ? cur_q : cur_q + 1'b1;
                end else begin
                    ena_d   = 1'b0;
                    n_d     = req_addr;
                    state_d = RST_LO;
                    rst_n_d = 1'b0;
                    cur_d   = '0;
                end
            end
            RST_LO: if (ph_end) begin
                cnt_d   = '0;
                state_d = RST_HI;
                rst_n_d = 1'b1;
            end
            RST_HI, INC_LO: if (ph_end) begin
                cnt_d   = '0;
                state_d = (n_q == '0) ? FINISH : INC_HI;
                inc_d   = n_q != '0;
                cur_d   = (n_q == '0) ? cur_q : cur_q + 1'b1;
            end
            INC_HI: if (ph_end) begin
                cnt_d   = '0;
                state_d = INC_LO;
                inc_d   = 1'b0;
                n_d     = n_q - 1'b1;
            end
            FINISH: begin
                state_d     = IDLE;
                done_d      = 1'b1;
                err_d       = rej_q;
                ena_d       = rej_q ? ena_q : req_ena_q;
                sel_valid_d = sel_valid_q | ~rej_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            cur_q       <= '0;
            rst_n_q     <= 1'b0;
            inc_q       <= 1'b0;
            ena_q       <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            sel_valid_q <= 1'b0;
            req_ena_q   <= 1'b0;
            rej_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            cur_q       <= cur_d;
            rst_n_q     <= rst_n_d;
            inc_q       <= inc_d;
            ena_q       <= ena_d;
            done_q      <= done_d;
            err_q       <= err_d;
            sel_valid_q <= sel_valid_d;
            req_ena_q   <= req_ena_d;
            rej_q       <= rej_d;
        end
    end

    assign req_ready      = state_q == IDLE;
    assign done           = done_q;
    assign err            = err_q;
    assign cur_addr       = cur_q;
    assign ctrl_sel_rst_n = rst_n_q;
    assign ctrl_sel_inc   = inc_q;
    assign ctrl_ena       = ena_q;
endmodule

// File: tb/tb_tt_mux_sel_driver.sv
// tb_tt_mux_sel_driver: directed request sequence with hand-computed latencies,
// pulse counts and resulting pad levels for PHASE_CYC=2.
module tb_tt_mux_sel_driver;
    logic       clk = 1'b0, rst = 1'b1;
    logic       req_valid = 1'b0, req_ena = 1'b0, req_fast = 1'b0;
    logic [9:0] req_addr = '0;
    logic       req_ready, done, err, ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena;
    logic [9:0] cur_addr;
    int checks = 0, failures = 0;
    int lat, pulses, highs, saw_rst, ena0, rdy0, err_done, overlap;

    tt_mux_sel_driver #(.ADDR_W(10), .ADDR_MAX(383), .PHASE_CYC(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_ena(req_ena), .req_fast(req_fast),
        .done(done), .err(err), .cur_addr(cur_addr),
        .ctrl_sel_rst_n(ctrl_sel_rst_n), .ctrl_sel_inc(ctrl_sel_inc), .ctrl_ena(ctrl_ena)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Handshake at the next edge (E0), then watch until done (bounded).
    task automatic do_req(input int addr, input bit ena, input bit fast);
        logic prev;
        req_addr  = 10'(addr);
        req_ena   = ena;
        req_fast  = fast;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; pulses = 0; highs = 0; saw_rst = 0; prev = 1'b0;
        ena0 = int'(ctrl_ena);
        rdy0 = int'(req_ready);
        while (!done && lat < 200) begin
            if (ctrl_sel_inc && !prev) pulses++;
            if (ctrl_sel_inc) highs++;
            if (!ctrl_sel_rst_n) saw_rst = 1;
            if (ctrl_sel_inc && !ctrl_sel_rst_n) overlap++;
            prev = ctrl_sel_inc;
            @(posedge clk); #1;
            lat++;
        end
        err_done = int'(err);
    endtask

    initial begin
        overlap = 0;
        #12;
        check("rst_sel_rst_n", int'(ctrl_sel_rst_n), 0);
        check("rst_inc", int'(ctrl_sel_inc), 0);
        check("rst_ena", int'(ctrl_ena), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_cur", int'(cur_addr), 0);
        check("rst_ready", int'(req_ready), 1);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        do_req(3, 1'b1, 1'b0);
        check("a3_lat", lat, 17);
        check("a3_pulses", pulses, 3);
        check("a3_highs", highs, 6);
        check("a3_rst", saw_rst, 1);
        check("a3_ready0", rdy0, 0);
        check("a3_ena", int'(ctrl_ena), 1);
        check("a3_cur", int'(cur_addr), 3);
        check("a3_err", err_done, 0);
        check("a3_ready_done", int'(req_ready), 1);

        do_req(5, 1'b1, 1'b1);
        check("a5_ena0", ena0, 0);
        check("a5_lat", lat, 9);
        check("a5_pulses", pulses, 2);
        check("a5_highs", highs, 4);
        check("a5_rst", saw_rst, 0);
        check("a5_cur", int'(cur_addr), 5);
        check("a5_ena", int'(ctrl_ena), 1);

        do_req(2, 1'b1, 1'b1);
        check("a2b_lat", lat, 13);
        check("a2b_pulses", pulses, 2);
        check("a2b_rst", saw_rst, 1);
        check("a2b_cur", int'(cur_addr), 2);

        do_req(400, 1'b0, 1'b0);
        check("bad_ready0", rdy0, 0);
        check("bad_lat", lat, 1);
        check("bad_err", err_done, 1);
        check("bad_pulses", pulses, 0);
        check("bad_rst", saw_rst, 0);
        check("bad_ena", int'(ctrl_ena), 1);
        check("bad_cur", int'(cur_addr), 2);
        check("bad_sel_rst_n", int'(ctrl_sel_rst_n), 1);

        do_req(0, 1'b0, 1'b0);
        check("a0_lat", lat, 5);
        check("a0_pulses", pulses, 0);
        check("a0_rst", saw_rst, 1);
        check("a0_cur", int'(cur_addr), 0);
        check("a0_ena", int'(ctrl_ena), 0);
        check("a0_ready_done", int'(req_ready), 1);
        do_req(2, 1'b1, 1'b1);
        check("b2b_lat", lat, 9);
        check("b2b_pulses", pulses, 2);
        check("b2b_rst", saw_rst, 0);
        check("b2b_cur", int'(cur_addr), 2);
        check("b2b_ena", int'(ctrl_ena), 1);

        req_addr = 10'd10; req_ena = 1'b1; req_fast = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        check("a10_inc2", int'(ctrl_sel_inc), 1);
        check("a10_cur2", int'(cur_addr), 2);
        rst = 1'b1; #1;
        check("mid_rst_sel_rst_n", int'(ctrl_sel_rst_n), 0);
        check("mid_rst_inc", int'(ctrl_sel_inc), 0);
        check("mid_rst_ena", int'(ctrl_ena), 0);
        check("mid_rst_cur", int'(cur_addr), 0);
        check("mid_rst_ready", int'(req_ready), 1);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        do_req(4, 1'b1, 1'b1);
        check("a4_lat", lat, 21);
        check("a4_pulses", pulses, 4);
        check("a4_cur", int'(cur_addr), 4);
        check("a4_ena", int'(ctrl_ena), 1);
        check("inc_vs_rst_overlap", overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tt_mux_sel_driver.md
Name: tt_mux_sel_driver

Overview:
- Initiator side of the pad-level design-select protocol that the TT controller responds to on ctrl_sel_rst_n, ctrl_sel_inc and ctrl_ena.
- Takes a target design address over a valid/ready request port and produces the selection waveform:
  - optional reset pulse on ctrl_sel_rst_n;
  - N increment pulses on ctrl_sel_inc;
  - final enable level on ctrl_ena.
- Lives in the board-side management logic, or in a test harness that drives the chip's control-high pads.

Parameters:
- ADDR_W, 10, width of design address and increment count.
- ADDR_MAX, 383, highest legal design address (G_X*G_Y-1 for the 16x24 grid).
- PHASE_CYC, 2, clock cycles per pulse phase (high or low); legal range 1..255.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- req_valid  input  1  request present.
- req_ready  output  1  block idle and able to accept a request.
- req_addr  input  ADDR_W  target design address, sampled at handshake.
- req_ena  input  1  value ctrl_ena takes after selection completes.
- req_fast  input  1  allow incremental select (skip reset phase) when possible.
- done  output  1  one-cycle pulse when a request finishes.
- err  output  1  one-cycle pulse, coincident with done, when the request was rejected.
- cur_addr  output  ADDR_W  increments issued since the last reset phase (address the mux currently points at).
- ctrl_sel_rst_n  output  1  to pad: mux select counter reset, active-low.
- ctrl_sel_inc  output  1  to pad: mux select counter increment.
- ctrl_ena  output  1  to pad: selected design enable.

Behaviour:
- All pad outputs, done, err and cur_addr are registered. req_ready is combinational (state==IDLE).
- Reset values:
  - ctrl_sel_rst_n=0 (mux held cleared until first request), ctrl_sel_inc=0, ctrl_ena=0.
  - done=0, err=0, cur_addr=0, req_ready=1.
  - Internal sel_valid=0.
- States: IDLE, RST_LO, RST_HI, INC_HI, INC_LO, FINISH. A phase counter counts PHASE_CYC cycles in each RST_*/INC_* state.
- Handshake: req_valid & req_ready at rising edge E0. req_addr, req_ena and req_fast are captured. Inputs while busy are ignored.
- Range check at handshake: if req_addr > ADDR_MAX, the request is rejected.
  - Go directly to FINISH; done=err=1 at edge E0+1.
  - No pad output changes, ctrl_ena is unchanged, cur_addr is unchanged.
- Path selection for a legal request:
  - Fast path when req_fast & sel_valid & (req_addr >= cur_addr): n = req_addr - cur_addr, skip the reset phase.
  - Otherwise full path: n = req_addr.
- At E0 (legal request): ctrl_ena <= 0.
- Full path:
  - RST_LO: ctrl_sel_rst_n=0 for PHASE_CYC cycles.
  - RST_HI: ctrl_sel_rst_n=1 for PHASE_CYC cycles.
  - cur_addr cleared to 0 on entering RST_LO.
- Increments, repeated n times:
  - INC_HI: ctrl_sel_inc=1 for PHASE_CYC cycles.
  - INC_LO: ctrl_sel_inc=0 for PHASE_CYC cycles.
  - cur_addr increments on each rising edge of ctrl_sel_inc.
  - n=0 skips the INC states entirely.
- FINISH, one cycle, at edge E0+L with L = 1 + (full ? 2*PHASE_CYC : 0) + 2*PHASE_CYC*n:
  - ctrl_ena <= req_ena, done=1, sel_valid=1.
  - cur_addr equals req_addr.
  - Return to IDLE; req_ready=1 in the cycle done is high, so back-to-back requests are allowed.
- ctrl_sel_inc is never high while ctrl_sel_rst_n is low. ctrl_sel_rst_n is never low during INC states.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). sel_valid clears, so the next request takes the full path.
- cur_addr saturates nowhere: n <= ADDR_MAX, so it never exceeds ADDR_MAX.

Test Plan:
- PHASE_CYC=2, after reset, request addr=3, ena=1, fast=0:
  - ctrl_sel_rst_n low for edges E0..E0+1, plus the reset-held interval before E0.
  - 3 inc pulses, each 2 cycles high and 2 cycles low.
  - done at E0+17 with ctrl_ena=1 and cur_addr=3.
- Then request addr=5, fast=1:
  - ctrl_ena drops at E0, no reset pulse, exactly 2 inc pulses.
  - done at E0+9, cur_addr=5.
- Then request addr=2, fast=1 (backwards):
  - Falls back to the full path: reset pulse plus 2 incs.
  - done at E0+13, cur_addr=2.
- Request addr=400:
  - req_ready low for 1 cycle; done=err=1 at E0+1.
  - Pads unchanged, ctrl_ena keeps its prior value, cur_addr unchanged.
- Request addr=0, fast=0: reset pulse only, zero inc pulses, done at E0+5. Request addr=2 fast=1 immediately after (handshake in the done cycle) is accepted.
- Assert rst during the 2nd inc pulse of an addr=10 request:
  - Outputs are at reset values the same cycle.
  - A following fast=1 request addr=4 performs the full path (reset pulse observed).
